// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the fetch unit AXIS master
package fetch_unit_pkg;
    localparam int WORD_W = 32;
    typedef enum logic [2:0] {INIT, IDLE, PREFETCH, STREAM, DONE} state_t;
endpackage

// File: rtl/fetch_unit_addr_gen.sv
// fetch_unit_addr_gen: word index, BRAM lookahead address and last-beat detect
// Ports: clk/rst (async active-high), load (latch clamped res_size, clear index),
//        hs (stream handshake this cycle), res_size, addr (BRAM read address),
//        last (presented word is the final one)
module fetch_unit_addr_gen #(
    parameter int BRAM_DEPTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  hs,
    input  logic [31:0]           res_size,
    output logic [BRAM_DEPTH-1:0] addr,
    output logic                  last
);
    localparam logic [BRAM_DEPTH:0] MAX_N = {1'b1, {BRAM_DEPTH{1'b0}}};
    logic [BRAM_DEPTH-1:0] idx_q;
    logic [BRAM_DEPTH:0]   n_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            n_q   <= '0;
        end else begin
            if (load)
                n_q <= (res_size > 32'(MAX_N)) ? MAX_N : res_size[BRAM_DEPTH:0];
            if (load || (hs && last))
                idx_q <= '0;
            else if (hs)
                idx_q <= idx_q + 1'b1;
        end
    end
    // n_q is one bit wider than idx_q so a full-depth transfer still has a valid N-1
    assign last = ({1'b0, idx_q} == n_q - 1'b1);
    // Lookahead on handshake keeps the BRAM output aligned with idx_q
    assign addr = hs ? idx_q + 1'b1 : idx_q;
endmodule

// File: rtl/fetch_unit_m00_axis.sv
// fetch_unit_m00_axis: streams res_size words from the result BRAM out on M_AXIS
// Ports: M_AXIS_ACLK/M_AXIS_ARESET (async active-high), VALID_PE2FU (level start),
//        res_size (word count), mat_res_addr/mat_res_dout (1-cycle-latency BRAM),
//        M_AXIS_TVALID/TDATA/TSTRB/TLAST/TREADY (AXI4-Stream master)
// Optional macro FETCH_UNIT_BEAT_CNT_EN adds beats_sent (handshakes this transfer)
//        and tx_done (1-cycle pulse on entry to DONE)
module fetch_unit_m00_axis
    import fetch_unit_pkg::*;
#(
    parameter int BRAM_DEPTH           = 10,
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_M_START_COUNT      = 32
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESET,
    input  logic                              VALID_PE2FU,
    input  logic [31:0]                       res_size,
    output logic [BRAM_DEPTH-1:0]             mat_res_addr,
    input  logic [WORD_W-1:0]                 mat_res_dout,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY
`ifdef FETCH_UNIT_BEAT_CNT_EN
    ,
    output logic [31:0]                       beats_sent,
    output logic                              tx_done
`endif
);
    state_t      state_q, state_d;
    logic [31:0] cnt_q;
    logic        load, hs, last;
    assign load          = (state_q == IDLE) && VALID_PE2FU;
    assign M_AXIS_TVALID = (state_q == STREAM);
    assign hs            = M_AXIS_TVALID && M_AXIS_TREADY;
    assign M_AXIS_TLAST  = M_AXIS_TVALID && last;
    assign M_AXIS_TDATA  = mat_res_dout;
    assign M_AXIS_TSTRB  = '1;
    fetch_unit_addr_gen #(.BRAM_DEPTH(BRAM_DEPTH)) u_addr_gen (
        .clk      (M_AXIS_ACLK),
        .rst      (M_AXIS_ARESET),
        .load     (load),
        .hs       (hs),
        .res_size (res_size),
        .addr     (mat_res_addr),
        .last     (last)
    );
    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == INIT) ? cnt_q + 32'd1 : cnt_q;
        end
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:     if (cnt_q + 32'd1 >= 32'(C_M_START_COUNT)) state_d = IDLE;
            IDLE:     if (VALID_PE2FU) state_d = (res_size == 32'd0) ? DONE : PREFETCH;
            PREFETCH: state_d = STREAM;
            STREAM:   if (hs && last) state_d = DONE;
            DONE:     if (!VALID_PE2FU) state_d = IDLE;
            default:  state_d = INIT;
        endcase
    end
`ifdef FETCH_UNIT_BEAT_CNT_EN
    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            beats_sent <= '0;
            tx_done    <= 1'b0;
        end else begin
            beats_sent <= load ? 32'd0 : beats_sent + 32'(hs);
            tx_done    <= (state_d == DONE) && (state_q != DONE);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit_m00_axis.sv
// tb_fetch_unit_m00_axis: directed + randomized bench with a BRAM model and beat-level reference
module tb_fetch_unit_m00_axis;
    logic        clk = 0, rst = 1, valid = 0, tready = 0;
    logic [31:0] res_size = 0;
    logic [9:0]  addr;
    logic [31:0] dout, tdata;
    logic [3:0]  tstrb;
    logic        tvalid, tlast;
    logic [31:0] mem [1024];
    int          errors = 0, checks = 0;
`ifdef FETCH_UNIT_BEAT_CNT_EN
    logic [31:0] beats_sent;
    logic        tx_done;
`endif

    fetch_unit_m00_axis dut (
        .M_AXIS_ACLK   (clk),
        .M_AXIS_ARESET (rst),
        .VALID_PE2FU   (valid),
        .res_size      (res_size),
        .mat_res_addr  (addr),
        .mat_res_dout  (dout),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TSTRB  (tstrb),
        .M_AXIS_TLAST  (tlast),
        .M_AXIS_TREADY (tready)
`ifdef FETCH_UNIT_BEAT_CNT_EN
        ,
        .beats_sent    (beats_sent),
        .tx_done       (tx_done)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) dout <= mem[addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < 1024; i++) mem[i] = rnd ? $urandom : 32'(i + 1);
    endtask

    task automatic wait_tvalid(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tvalid && n < bound);
    endtask

    task automatic restart(input int rs);
        int n;
        valid = 0;
        repeat (2) @(negedge clk);
        res_size = rs;
        valid = 1;
        wait_tvalid(10, n);
        chk("start_latency", n, 2);
    endtask

    task automatic no_retrigger(input int c);
        repeat (c) begin
            @(negedge clk);
            chk("no_retrigger", tvalid, 0);
        end
    endtask

    // Expects to be called at the negedge where the first TVALID is visible
    task automatic burst(input int n, input int mode, input bit drop, output int cyc);
        int k = 0;
        cyc = 0;
        res_size = $urandom;
        if (drop) valid = 0;
        while (k < n && cyc < 4 * n + 20) begin
            tready = (mode == 0) || (mode == 1 && cyc % 2 == 0) ||
                     (mode == 2 && $urandom_range(0, 1) == 1);
            #1;
            chk("tvalid", tvalid, 1);
            chk("tdata", tdata, mem[k]);
            chk("tlast", tlast, k == n - 1);
            chk("addr", addr, tready ? (k + 1) % 1024 : k);
            if (tready) k++;
            cyc++;
            @(negedge clk);
        end
        chk("beats", k, n);
        tready = 0;
        #1;
        chk("tvalid_end", tvalid, 0);
        chk("addr_end", addr, 0);
`ifdef FETCH_UNIT_BEAT_CNT_EN
        chk("tx_done", tx_done, 1);
        chk("beats_sent", beats_sent, n);
`endif
    endtask

    initial begin
        int n, cyc;
        fill(0);
        res_size = 16;
        #23;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_addr", addr, 0);
        chk("tstrb", tstrb, 4'hF);
        @(negedge clk);
        rst = 0;
        valid = 1;
        wait_tvalid(100, n);
        chk("init_latency", n, 34);
        burst(16, 0, 0, cyc);
        chk("full_rate_cycles", cyc, 16);
        no_retrigger(6);
        restart(16);
        burst(16, 1, 0, cyc);
        chk("toggle_cycles", cyc, 31);
        valid = 0;
        repeat (2) @(negedge clk);
        res_size = 0;
        valid = 1;
        no_retrigger(8);
        res_size = 4;
        no_retrigger(5);
        restart(4);
        burst(4, 0, 0, cyc);
        no_retrigger(6);
        restart(4);
        burst(4, 0, 0, cyc);
        fill(1);
        repeat (4) begin
            n = $urandom_range(1, 40);
            restart(n);
            burst(n, 2, 1, cyc);
        end
        restart(2000);
        burst(1024, 0, 0, cyc);
        fill(0);
        restart(16);
        tready = 1;
        repeat (5) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_tvalid", tvalid, 0);
        chk("arst_addr", addr, 0);
        chk("arst_tlast", tlast, 0);
        @(negedge clk);
        rst = 0;
        tready = 0;
        wait_tvalid(100, n);
        chk("reinit_latency", n, 34);
        burst(16, 0, 0, cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
